// File: rtl/flash_cmd_pkg.sv
// Shared encodings for the flash command sequencer: ops, FSM states,
// CSR layout and the word-address to sector mapping.
package flash_cmd_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_ERASE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_UNPROT,
    S_WR_REQ,
    S_RD_REQ,
    S_RD_WAIT,
    S_POLL,
    S_POLL_CHK,
    S_REPROT,
    S_DONE
  } state_e;

  localparam logic CSR_STATUS  = 1'b0;
  localparam logic CSR_CONTROL = 1'b1;

  localparam int unsigned ST_BUSY_LSB = 0;
  localparam int unsigned ST_READ_OK  = 2;
  localparam int unsigned ST_WRITE_OK = 3;
  localparam int unsigned ST_ERASE_OK = 4;

  localparam logic [1:0] BUSY_IDLE  = 2'b00;
  localparam logic [1:0] BUSY_ERASE = 2'b01;
  localparam logic [1:0] BUSY_WRITE = 2'b10;
  localparam logic [1:0] BUSY_READ  = 2'b11;

  localparam int unsigned CTRL_PAGE_LSB   = 0;
  localparam int unsigned CTRL_SECTOR_LSB = 20;
  localparam int unsigned CTRL_PROT_LSB   = 23;

  localparam logic [2:0]  SECTOR_NONE = 3'd7;
  localparam logic [31:0] PROTECT_ALL = 32'hFFFF_FFFF;
  localparam int unsigned NUM_SECTORS = 5;

  // 8K-word sectors starting at word 0; words past sector 5 decode to 0 (no sector).
  function automatic logic [2:0] addr_to_sector(input logic [15:0] addr);
    if (addr[15:13] < 3'd5) return addr[15:13] + 3'd1;
    return 3'd0;
  endfunction

  function automatic logic sector_allowed(input logic [2:0] sector, input logic [4:0] mask);
    logic ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < NUM_SECTORS; i++)
      if (sector == 3'(i + 1)) ok = mask[i];
    return ok;
  endfunction

  function automatic logic [31:0] ctrl_unprotect(input logic [2:0] sector, input logic [2:0] erase_field);
    logic [31:0] w;
    w = PROTECT_ALL;
    w[CTRL_SECTOR_LSB +: 3] = erase_field;
    for (int unsigned i = 0; i < NUM_SECTORS; i++)
      if (sector == 3'(i + 1)) w[CTRL_PROT_LSB + i] = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/flash_cmd_seq.sv
// Sequences single-beat READ/WRITE/SECTOR_ERASE commands onto the flash IP's
// CSR and data ports, returning one response per accepted command.
module flash_cmd_seq
  import flash_cmd_pkg::*;
#(
  parameter logic [23:0] POLL_TIMEOUT = 24'd12_000_000,
  parameter logic [4:0]  SECTOR_MASK  = 5'b11111
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy,
  output logic        avmm_csr_addr,
  output logic        avmm_csr_read,
  output logic        avmm_csr_write,
  output logic [31:0] avmm_csr_writedata,
  input  logic [31:0] avmm_csr_readdata,
  output logic [15:0] avmm_data_addr,
  output logic        avmm_data_read,
  output logic        avmm_data_write,
  output logic [31:0] avmm_data_writedata,
  input  logic [31:0] avmm_data_readdata,
  input  logic        avmm_data_waitrequest,
  input  logic        avmm_data_readdatavalid,
  output logic [1:0]  avmm_data_burstcount
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [23:0] cnt_q, cnt_d;
  logic [31:0] ctrl_q, ctrl_d;

  logic [23:0] cnt_inc;
  logic        timeout_hit;
  logic [2:0]  tgt_sector;
  logic [2:0]  erase_field;
  logic        op_ok;
  logic        unused_status;

  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 24'd1;
  assign timeout_hit = (cnt_inc >= POLL_TIMEOUT);

  assign avmm_data_burstcount = 2'd1;
  assign rsp_rdata            = rdata_q;
  assign rsp_error            = err_q;
  assign unused_status        = ^{avmm_csr_readdata[31:5], avmm_csr_readdata[ST_READ_OK]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      ctrl_q  <= PROTECT_ALL;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;

    cmd_ready           = 1'b0;
    busy                = 1'b1;
    rsp_valid           = 1'b0;
    avmm_csr_addr       = CSR_STATUS;
    avmm_csr_read       = 1'b0;
    avmm_csr_write      = 1'b0;
    avmm_csr_writedata  = '0;
    avmm_data_addr      = '0;
    avmm_data_read      = 1'b0;
    avmm_data_write     = 1'b0;
    avmm_data_writedata = '0;

    tgt_sector  = (op_q == OP_WRITE) ? addr_to_sector(addr_q) : addr_q[2:0];
    erase_field = (op_q == OP_WRITE) ? SECTOR_NONE : addr_q[2:0];
    op_ok       = (op_q == OP_WRITE) ? avmm_csr_readdata[ST_WRITE_OK]
                                     : avmm_csr_readdata[ST_ERASE_OK];

    if (state_q == S_POLL || state_q == S_POLL_CHK || state_q == S_RD_WAIT)
      cnt_d = cnt_inc;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          unique case (op_e'(cmd_op))
            OP_READ:  state_d = S_RD_REQ;
            OP_WRITE: state_d = S_UNPROT;
            OP_ERASE: begin
              if (sector_allowed(cmd_addr[2:0], SECTOR_MASK)) begin
                state_d = S_UNPROT;
              end else begin
                err_d   = 1'b1;
                state_d = S_DONE;
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_UNPROT: begin
        if (!sector_allowed(tgt_sector, SECTOR_MASK)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          ctrl_d             = ctrl_unprotect(tgt_sector, erase_field);
          avmm_csr_write     = 1'b1;
          avmm_csr_addr      = CSR_CONTROL;
          avmm_csr_writedata = ctrl_d;
          state_d            = (op_q == OP_WRITE) ? S_WR_REQ : S_POLL;
        end
      end
      S_WR_REQ: begin
        avmm_data_write     = 1'b1;
        avmm_data_addr      = addr_q;
        avmm_data_writedata = wdata_q;
        if (!avmm_data_waitrequest) state_d = S_POLL;
      end
      S_RD_REQ: begin
        avmm_data_read = 1'b1;
        avmm_data_addr = addr_q;
        if (!avmm_data_waitrequest) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // A READ never unprotected anything, so its timeout skips the re-protect write.
        if (avmm_data_readdatavalid) begin
          rdata_d = avmm_data_readdata;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_POLL: begin
        avmm_csr_read = 1'b1;
        avmm_csr_addr = CSR_STATUS;
        if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_REPROT;
        end else begin
          state_d = S_POLL_CHK;
        end
      end
      S_POLL_CHK: begin
        if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_REPROT;
        end else if (avmm_csr_readdata[ST_BUSY_LSB +: 2] != BUSY_IDLE) begin
          state_d = S_POLL;
        end else begin
          if (!op_ok) err_d = 1'b1;
          state_d = S_REPROT;
        end
      end
      S_REPROT: begin
        ctrl_d             = PROTECT_ALL;
        avmm_csr_write     = 1'b1;
        avmm_csr_addr      = CSR_CONTROL;
        avmm_csr_writedata = PROTECT_ALL;
        state_d            = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_flash_cmd_seq.sv
// Scoreboard bench for flash_cmd_seq with a reactive flash IP model and a
// command-level reference model.
module tb_flash_cmd_seq;

  localparam int         TMO  = 20;
  localparam logic [4:0] MASK = 5'b10111;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;
  logic        avmm_csr_addr;
  logic        avmm_csr_read;
  logic        avmm_csr_write;
  logic [31:0] avmm_csr_writedata;
  logic [31:0] avmm_csr_readdata;
  logic [15:0] avmm_data_addr;
  logic        avmm_data_read;
  logic        avmm_data_write;
  logic [31:0] avmm_data_writedata;
  logic [31:0] avmm_data_readdata;
  logic        avmm_data_waitrequest;
  logic        avmm_data_readdatavalid;
  logic [1:0]  avmm_data_burstcount;

  flash_cmd_seq #(.POLL_TIMEOUT(24'(TMO)), .SECTOR_MASK(MASK)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .busy(busy),
    .avmm_csr_addr(avmm_csr_addr), .avmm_csr_read(avmm_csr_read),
    .avmm_csr_write(avmm_csr_write), .avmm_csr_writedata(avmm_csr_writedata),
    .avmm_csr_readdata(avmm_csr_readdata),
    .avmm_data_addr(avmm_data_addr), .avmm_data_read(avmm_data_read),
    .avmm_data_write(avmm_data_write), .avmm_data_writedata(avmm_data_writedata),
    .avmm_data_readdata(avmm_data_readdata), .avmm_data_waitrequest(avmm_data_waitrequest),
    .avmm_data_readdatavalid(avmm_data_readdatavalid), .avmm_data_burstcount(avmm_data_burstcount)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Flash IP configuration for the next command, written only by stimulus.
  int          cfg_wait  = 0;
  int          cfg_polls = 0;
  int          cfg_rlat  = 1;
  logic [1:0]  cfg_busy  = 2'b01;
  logic [4:0]  cfg_final = 5'b0;
  bit          cfg_stray = 1'b0;
  bit          cfg_drop  = 1'b0;
  logic [31:0] cfg_rword = '0;

  int          wait_left;
  int          polls_left;
  int          rd_cnt;
  logic        rdv;
  logic [31:0] rdv_data;
  logic [31:0] csr_rdata;

  assign avmm_data_waitrequest   = (wait_left != 0);
  assign avmm_data_readdatavalid = rdv;
  assign avmm_data_readdata      = rdv_data;
  assign avmm_csr_readdata       = csr_rdata;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_left  <= 0;
      polls_left <= 0;
      rd_cnt     <= 0;
      rdv        <= 1'b0;
      rdv_data   <= '0;
      csr_rdata  <= '0;
    end else begin
      rdv <= 1'b0;
      if (cmd_valid && cmd_ready) begin
        wait_left  <= cfg_wait;
        polls_left <= cfg_polls;
      end else if ((avmm_data_read || avmm_data_write) && wait_left != 0) begin
        wait_left <= wait_left - 1;
      end
      if (avmm_csr_read) begin
        if (polls_left != 0) begin
          csr_rdata  <= {27'h0, 3'b111, cfg_busy};
          polls_left <= polls_left - 1;
        end else begin
          csr_rdata <= {27'h0, cfg_final};
        end
        if (cfg_stray) begin
          rdv      <= 1'b1;
          rdv_data <= 32'hBAD0_BAD0;
        end
      end
      if (rd_cnt != 0) begin
        rd_cnt <= rd_cnt - 1;
        if (rd_cnt == 1) begin
          rdv      <= 1'b1;
          rdv_data <= cfg_rword;
        end
      end else if (avmm_data_read && wait_left == 0 && !cfg_drop) begin
        rd_cnt <= cfg_rlat;
      end
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          csr_ok;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [31:0] csrw_q[$];
  logic [47:0] dataw_q[$];
  logic [15:0] rdaddr_q[$];
  int          rsp_seen = 0;
  int unsigned rsp_cyc  = 0;
  int          csr_reads = 0;

  always @(negedge clock) begin
    if (reset) begin
      csr_reads = 0;
    end else begin
      if (avmm_csr_read) begin
        csr_reads++;
        chk("csr_read_addr", 32'(avmm_csr_addr), 32'd0);
      end
      if (avmm_csr_write) begin
        chk("csr_write_expected", 32'(csrw_q.size() != 0), 32'd1);
        chk("csr_write_addr", 32'(avmm_csr_addr), 32'd1);
        if (csrw_q.size() != 0) chk("csr_write_data", avmm_csr_writedata, csrw_q.pop_front());
      end
      if (avmm_data_write && !avmm_data_waitrequest) begin
        chk("data_write_expected", 32'(dataw_q.size() != 0), 32'd1);
        if (dataw_q.size() != 0) begin
          logic [47:0] e;
          e = dataw_q.pop_front();
          chk("data_write_addr", 32'(avmm_data_addr), 32'(e[47:32]));
          chk("data_write_data", avmm_data_writedata, e[31:0]);
        end
      end
      if (avmm_data_read && !avmm_data_waitrequest) begin
        chk("data_read_expected", 32'(rdaddr_q.size() != 0), 32'd1);
        if (rdaddr_q.size() != 0) chk("data_read_addr", 32'(avmm_data_addr), 32'(rdaddr_q.pop_front()));
      end
      if (rsp_valid) begin
        chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
        if (rsp_q.size() != 0) begin
          rsp_t e;
          e = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_error", 32'(rsp_error), 32'(e.err));
          chk("bus_writes_done_before_rsp", 32'(csrw_q.size() + dataw_q.size()), 32'd0);
          if (!e.csr_ok) chk("no_csr_reads", 32'(csr_reads), 32'd0);
        end
        csr_reads = 0;
        rsp_cyc   = cyc;
        rsp_seen++;
      end
    end
  end

  function automatic logic [31:0] exp_ctrl(input int s, input int field);
    logic [4:0] prot;
    prot = 5'h1F & ~(5'd1 << (s - 1));
    return {4'hF, prot, 3'(field), 20'hF_FFFF};
  endfunction

  function automatic bit sector_ok(input int s);
    return (s >= 1 && s <= 5) ? bit'(MASK[s-1]) : 1'b0;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] wd,
                       output int lat);
    rsp_t        e;
    int          s;
    int          n0;
    int unsigned start;
    bit          timed_out;
    e.rdata   = '0;
    e.err     = 1'b0;
    e.csr_ok  = 1'b0;
    timed_out = (2 * (cfg_polls + 1) >= TMO);
    case (op)
      2'd0: begin
        rdaddr_q.push_back(addr);
        if (cfg_drop) e.err = 1'b1;
        else e.rdata = cfg_rword;
      end
      2'd1: begin
        s = int'(addr) / 8192 + 1;
        if (!sector_ok(s)) e.err = 1'b1;
        else begin
          csrw_q.push_back(exp_ctrl(s, 7));
          dataw_q.push_back({addr, wd});
          csrw_q.push_back(32'hFFFF_FFFF);
          e.csr_ok = 1'b1;
          e.err    = timed_out || !cfg_final[3];
        end
      end
      2'd2: begin
        s = int'(addr[2:0]);
        if (!sector_ok(s)) e.err = 1'b1;
        else begin
          csrw_q.push_back(exp_ctrl(s, s));
          csrw_q.push_back(32'hFFFF_FFFF);
          e.csr_ok = 1'b1;
          e.err    = timed_out || !cfg_final[4];
        end
      end
      default: e.err = 1'b1;
    endcase
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clock);
    chk("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
    rsp_q.push_back(e);
    n0        = rsp_seen;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wd;
    @(negedge clock);
    start     = cyc;
    // A second request while busy must be dropped, not queued.
    cmd_op    = 2'd3;
    cmd_addr  = ~addr;
    @(negedge clock);
    cmd_valid = 1'b0;
    for (int i = 0; i < 300 && rsp_seen == n0; i++) @(negedge clock);
    chk("rsp_arrived", 32'(rsp_seen - n0), 32'd1);
    lat = int'(rsp_cyc - start);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n0;
    logic [1:0]  op;
    logic [15:0] addr;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    repeat (3) @(negedge clock);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp", {rsp_rdata[30:0], rsp_valid | rsp_error | rsp_rdata[31]}, 32'd0);
    chk("reset_strobes", 32'({avmm_csr_read, avmm_csr_write, avmm_data_read, avmm_data_write, avmm_csr_addr}), 32'd0);
    chk("reset_burstcount", 32'(avmm_data_burstcount), 32'd1);
    chk("reset_data_addr", 32'(avmm_data_addr), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    cfg_wait = 2; cfg_rlat = 1; cfg_rword = 32'hDEAD_BEEF;
    issue(2'd0, 16'h0123, 32'h0, lat);

    cfg_wait = 0; cfg_polls = 3; cfg_busy = 2'b10; cfg_final = 5'b01000; cfg_stray = 1'b1;
    issue(2'd1, 16'h0040, 32'hA5A5_5A5A, lat);

    cfg_polls = 1; cfg_busy = 2'b01; cfg_final = 5'b01000; cfg_stray = 1'b0;
    issue(2'd2, 16'h0003, 32'h0, lat);

    issue(2'd2, 16'h0006, 32'h0, lat);
    chk("erase_bad_sector_latency_le1", 32'(lat <= 1), 32'd1);
    issue(2'd3, 16'h0001, 32'h0, lat);
    chk("reserved_op_latency_le1", 32'(lat <= 1), 32'd1);
    issue(2'd2, 16'h0004, 32'h0, lat);
    issue(2'd1, 16'h6000, 32'h1234_5678, lat);
    issue(2'd1, 16'hC000, 32'h1234_5678, lat);

    cfg_polls = 1000000; cfg_busy = 2'b01; cfg_final = 5'b11000;
    issue(2'd1, 16'h2345, 32'hCAFE_F00D, lat);
    chk("write_timeout_latency_range", 32'(lat >= TMO && lat <= TMO + 10), 32'd1);
    issue(2'd2, 16'h0005, 32'h0, lat);
    chk("erase_timeout_latency_range", 32'(lat >= TMO && lat <= TMO + 10), 32'd1);
    cfg_polls = 0; cfg_drop = 1'b1;
    issue(2'd0, 16'h7777, 32'h0, lat);
    chk("read_timeout_latency_range", 32'(lat >= TMO && lat <= TMO + 10), 32'd1);
    cfg_drop = 1'b0;

    // Reset while the data write is stalled on waitrequest.
    cfg_wait = 40; cfg_polls = 0; cfg_final = 5'b01000;
    csrw_q.push_back(exp_ctrl(1, 7));
    n0 = rsp_seen;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 16'h0100; cmd_wdata = 32'h0BAD_F00D;
    @(negedge clock);
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !avmm_data_write; i++) @(negedge clock);
    chk("wr_req_reached", 32'(avmm_data_write), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_reset_strobes", 32'({avmm_csr_read, avmm_csr_write, avmm_data_read, avmm_data_write}), 32'd0);
    csrw_q.delete(); dataw_q.delete(); rdaddr_q.delete(); rsp_q.delete();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    cfg_wait = 0;
    repeat (3) @(negedge clock);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("no_rsp_after_reset", 32'(rsp_seen - n0), 32'd0);

    for (int n = 0; n < 40; n++) begin
      op        = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) op = 2'd3;
      else if (op == 2'd3) op = 2'd1;
      addr      = 16'($urandom);
      if (op == 2'd2) addr[2:0] = 3'($urandom_range(0, 7));
      cfg_wait  = int'($urandom_range(0, 3));
      cfg_rlat  = int'($urandom_range(1, 4));
      cfg_polls = int'($urandom_range(0, 5));
      cfg_busy  = 2'($urandom_range(1, 3));
      cfg_final = {3'($urandom), 2'b00};
      cfg_stray = 1'($urandom);
      cfg_rword = $urandom;
      issue(op, addr, $urandom, lat);
    end

    repeat (5) @(negedge clock);
    chk("scoreboard_drained", 32'(rsp_q.size() + csrw_q.size() + dataw_q.size() + rdaddr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
